// File: rtl/park_pkg.sv
// Shared types and constants for the parking gate front-end.
// Holds the gate state encoding, default timing constants and a counter-width helper.
package park_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    IN_O       = 3'd1,
    IN_B       = 3'd2,
    IN_I       = 3'd3,
    OUT_I      = 3'd4,
    OUT_B      = 3'd5,
    OUT_O      = 3'd6,
    WAIT_CLEAR = 3'd7
  } gate_state_e;

  localparam int DEBOUNCE_DEF = 4;
  localparam int TIMEOUT_DEF  = 255;

  // Bits needed to hold the values 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int TIMEOUT_W_DEF = cnt_width(TIMEOUT_DEF);

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser followed by a debouncer: level follows the synchronised
// input only after DEBOUNCE consecutive samples that differ from the current level.
module sensor_debounce
  import park_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  localparam int CW = cnt_width(DEBOUNCE);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
      cnt_q  <= '0;
      level  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      // The counter only runs while the synchronised sample disagrees with level.
      if (sync_q[1] == level) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE - 1)) begin
        cnt_q <= '0;
        level <= sync_q[1];
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/park_entry_gate.sv
// Gate front-end: conditions the two loop sensors, decodes direction with a
// sequence FSM, drives the barrier and emits car_in/car_out/entry_denied/fault pulses.
module park_entry_gate
  import park_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sensor_outer,
  input  logic        sensor_inner,
  input  logic        parking_full,
  output logic        car_in,
  output logic        car_out,
  output logic        barrier_up,
  output logic        entry_denied,
  output logic        fault,
  output gate_state_e state_dbg
);

  localparam int TW = cnt_width(TIMEOUT);

  logic so, si, so_d, si_d;
  logic [1:0] sv;
  logic sens_chg, timed_out;
  logic hold, bad;
  logic car_in_d, car_out_d, denied_d, fault_d;
  logic [TW-1:0] tcnt_q;
  gate_state_e state_q, state_d;

  sensor_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_outer (
    .clk(clk), .rst_n(rst_n), .raw(sensor_outer), .level(so)
  );

  sensor_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_inner (
    .clk(clk), .rst_n(rst_n), .raw(sensor_inner), .level(si)
  );

  assign sv        = {so, si};
  assign sens_chg  = (so != so_d) || (si != si_d);
  assign timed_out = (tcnt_q == TW'(TIMEOUT));
  assign state_dbg = state_q;

  // hold marks a sequence state seeing its own sensor pattern; bad marks a skipped step.
  always_comb begin
    state_d   = state_q;
    hold      = 1'b0;
    bad       = 1'b0;
    car_in_d  = 1'b0;
    car_out_d = 1'b0;
    denied_d  = 1'b0;
    case (state_q)
      IDLE: begin
        case (sv)
          2'b10: begin
            if (parking_full) begin
              state_d  = WAIT_CLEAR;
              denied_d = 1'b1;
            end else begin
              state_d = IN_O;
            end
          end
          2'b01:   state_d = OUT_I;
          2'b11:   bad = 1'b1;
          default: ;
        endcase
      end
      IN_O: begin
        case (sv)
          2'b11:   state_d = IN_B;
          2'b00:   state_d = IDLE;
          2'b10:   hold = 1'b1;
          default: bad = 1'b1;
        endcase
      end
      IN_B: begin
        case (sv)
          2'b01:   state_d = IN_I;
          2'b10:   state_d = IN_O;
          2'b11:   hold = 1'b1;
          default: bad = 1'b1;
        endcase
      end
      IN_I: begin
        case (sv)
          2'b00: begin
            state_d  = IDLE;
            car_in_d = 1'b1;
          end
          2'b11:   state_d = IN_B;
          2'b01:   hold = 1'b1;
          default: bad = 1'b1;
        endcase
      end
      OUT_I: begin
        case (sv)
          2'b11:   state_d = OUT_B;
          2'b00:   state_d = IDLE;
          2'b01:   hold = 1'b1;
          default: bad = 1'b1;
        endcase
      end
      OUT_B: begin
        case (sv)
          2'b10:   state_d = OUT_O;
          2'b01:   state_d = OUT_I;
          2'b11:   hold = 1'b1;
          default: bad = 1'b1;
        endcase
      end
      OUT_O: begin
        case (sv)
          2'b00: begin
            state_d   = IDLE;
            car_out_d = 1'b1;
          end
          2'b11:   state_d = OUT_B;
          2'b10:   hold = 1'b1;
          default: bad = 1'b1;
        endcase
      end
      WAIT_CLEAR: begin
        if (sv == 2'b00) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    fault_d = bad || (hold && timed_out && !sens_chg);
    if (fault_d) state_d = WAIT_CLEAR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      so_d         <= 1'b0;
      si_d         <= 1'b0;
      tcnt_q       <= '0;
      car_in       <= 1'b0;
      car_out      <= 1'b0;
      entry_denied <= 1'b0;
      fault        <= 1'b0;
      barrier_up   <= 1'b0;
    end else begin
      state_q      <= state_d;
      so_d         <= so;
      si_d         <= si;
      car_in       <= car_in_d;
      car_out      <= car_out_d;
      entry_denied <= denied_d;
      fault        <= fault_d;
      barrier_up   <= !(state_d inside {IDLE, WAIT_CLEAR});
      if ((state_d != state_q) || sens_chg) begin
        tcnt_q <= '0;
      end else if (!timed_out) begin
        tcnt_q <= tcnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_park_entry_gate.sv
// Directed bench for park_entry_gate: entry, exit, full lot, glitch, timeout,
// skipped-sequence fault and mid-sequence reset, with hand-computed timing.
module tb_park_entry_gate;
  import park_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sensor_outer, sensor_inner, parking_full;
  logic        car_in, car_out, barrier_up, entry_denied, fault;
  gate_state_e state_dbg;

  int n_assert = 0;
  int n_fail   = 0;
  int cnt_in = 0, cnt_out = 0, cnt_denied = 0, cnt_fault = 0, cnt_multi = 0, cnt_bar = 0;
  int bar_snap;

  park_entry_gate #(.DEBOUNCE(4), .TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n),
    .sensor_outer(sensor_outer), .sensor_inner(sensor_inner),
    .parking_full(parking_full),
    .car_in(car_in), .car_out(car_out), .barrier_up(barrier_up),
    .entry_denied(entry_denied), .fault(fault), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Pulse and barrier bookkeeping, sampled mid-cycle.
  always @(negedge clk) begin
    cnt_in     += int'(car_in);
    cnt_out    += int'(car_out);
    cnt_denied += int'(entry_denied);
    cnt_fault  += int'(fault);
    cnt_bar    += int'(barrier_up);
    if ((int'(car_in) + int'(car_out) + int'(entry_denied) + int'(fault)) > 1) cnt_multi++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic o, input logic i);
    sensor_outer = o;
    sensor_inner = i;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    parking_full = 1'b0;
    drive(1'b0, 1'b0);
    cyc(3);
    check("reset_state", 32'(state_dbg), 32'(IDLE));
    check("reset_outputs", {27'd0, car_in, car_out, barrier_up, entry_denied, fault}, 32'd0);
    rst_n = 1'b1;
    cyc(2);

    // Entry: outer -> both -> inner -> none, 10 cycles each.
    drive(1'b1, 1'b0);
    cyc(6);
    check("entry_bar_pre", 32'(barrier_up), 32'd0);
    cyc(1);
    check("entry_bar_up", 32'(barrier_up), 32'd1);
    check("entry_st_in_o", 32'(state_dbg), 32'(IN_O));
    cyc(3);
    drive(1'b1, 1'b1);
    cyc(10);
    check("entry_st_in_b", 32'(state_dbg), 32'(IN_B));
    drive(1'b0, 1'b1);
    cyc(10);
    check("entry_st_in_i", 32'(state_dbg), 32'(IN_I));
    drive(1'b0, 1'b0);
    cyc(6);
    check("entry_car_in_pre", 32'(car_in), 32'd0);
    check("entry_bar_hold", 32'(barrier_up), 32'd1);
    cyc(1);
    check("entry_car_in", 32'(car_in), 32'd1);
    check("entry_bar_down", 32'(barrier_up), 32'd0);
    cyc(1);
    check("entry_car_in_width", 32'(car_in), 32'd0);
    cyc(2);
    check("entry_cnt_in", 32'(cnt_in), 32'd1);

    // Exit: inner -> both -> outer -> none.
    drive(1'b0, 1'b1);
    cyc(7);
    check("exit_st_out_i", 32'(state_dbg), 32'(OUT_I));
    check("exit_bar_up", 32'(barrier_up), 32'd1);
    cyc(3);
    drive(1'b1, 1'b1);
    cyc(10);
    check("exit_st_out_b", 32'(state_dbg), 32'(OUT_B));
    drive(1'b1, 1'b0);
    cyc(10);
    check("exit_st_out_o", 32'(state_dbg), 32'(OUT_O));
    drive(1'b0, 1'b0);
    cyc(6);
    check("exit_car_out_pre", 32'(car_out), 32'd0);
    cyc(1);
    check("exit_car_out", 32'(car_out), 32'd1);
    check("exit_bar_down", 32'(barrier_up), 32'd0);
    cyc(3);
    check("exit_cnt_out", 32'(cnt_out), 32'd1);
    check("exit_cnt_in", 32'(cnt_in), 32'd1);

    // Lot full: entry refused, exit still allowed.
    parking_full = 1'b1;
    drive(1'b1, 1'b0);
    cyc(7);
    check("full_denied", 32'(entry_denied), 32'd1);
    check("full_bar", 32'(barrier_up), 32'd0);
    check("full_st_wait", 32'(state_dbg), 32'(WAIT_CLEAR));
    cyc(1);
    check("full_denied_width", 32'(entry_denied), 32'd0);
    cyc(5);
    drive(1'b0, 1'b0);
    cyc(10);
    check("full_st_idle", 32'(state_dbg), 32'(IDLE));
    drive(1'b0, 1'b1);
    cyc(10);
    drive(1'b1, 1'b1);
    cyc(10);
    drive(1'b1, 1'b0);
    cyc(10);
    drive(1'b0, 1'b0);
    cyc(7);
    check("full_exit_car_out", 32'(car_out), 32'd1);
    cyc(3);
    check("full_cnt_out", 32'(cnt_out), 32'd2);
    check("full_cnt_in", 32'(cnt_in), 32'd1);
    check("full_cnt_denied", 32'(cnt_denied), 32'd1);
    parking_full = 1'b0;

    // 3-cycle glitch on outer is ignored.
    bar_snap = cnt_bar;
    drive(1'b1, 1'b0);
    cyc(3);
    drive(1'b0, 1'b0);
    cyc(12);
    check("glitch_st", 32'(state_dbg), 32'(IDLE));
    check("glitch_bar_cycles", 32'(cnt_bar - bar_snap), 32'd0);

    // Outer held 8 cycles then backs out: barrier up then down, no pulse.
    drive(1'b1, 1'b0);
    cyc(8);
    check("backout_bar_up", 32'(barrier_up), 32'd1);
    drive(1'b0, 1'b0);
    cyc(6);
    check("backout_bar_hold", 32'(barrier_up), 32'd1);
    cyc(1);
    check("backout_bar_down", 32'(barrier_up), 32'd0);
    check("backout_st", 32'(state_dbg), 32'(IDLE));
    cyc(2);
    check("backout_pulses", 32'(cnt_in + cnt_out + cnt_fault + cnt_denied), 32'd4);

    // Outer held alone for 300 cycles: timeout fault after 263 edges.
    drive(1'b1, 1'b0);
    cyc(262);
    check("tmo_fault_pre", 32'(fault), 32'd0);
    check("tmo_bar_pre", 32'(barrier_up), 32'd1);
    cyc(1);
    check("tmo_fault", 32'(fault), 32'd1);
    check("tmo_bar_down", 32'(barrier_up), 32'd0);
    check("tmo_st_wait", 32'(state_dbg), 32'(WAIT_CLEAR));
    cyc(1);
    check("tmo_fault_width", 32'(fault), 32'd0);
    cyc(36);
    check("tmo_still_wait", 32'(state_dbg), 32'(WAIT_CLEAR));
    drive(1'b0, 1'b0);
    cyc(7);
    check("tmo_cleared", 32'(state_dbg), 32'(IDLE));
    drive(1'b1, 1'b0);
    cyc(7);
    check("tmo_reentry", 32'(state_dbg), 32'(IN_O));
    cyc(3);
    drive(1'b1, 1'b1);
    cyc(10);
    check("rst_pre_in_b", 32'(state_dbg), 32'(IN_B));
    check("rst_pre_bar", 32'(barrier_up), 32'd1);

    // Asynchronous reset in IN_B clears outputs without waiting for a clock edge.
    #2;
    rst_n = 1'b0;
    drive(1'b0, 1'b0);
    #1;
    check("rst_async_bar", 32'(barrier_up), 32'd0);
    check("rst_async_st", 32'(state_dbg), 32'(IDLE));
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    drive(1'b1, 1'b0);
    cyc(10);
    drive(1'b1, 1'b1);
    cyc(10);
    drive(1'b0, 1'b1);
    cyc(10);
    drive(1'b0, 1'b0);
    cyc(7);
    check("rst_entry_car_in", 32'(car_in), 32'd1);
    cyc(3);
    check("rst_cnt_in", 32'(cnt_in), 32'd2);

    // Both sensors rising together from IDLE is a skipped sequence.
    drive(1'b1, 1'b1);
    cyc(7);
    check("both_fault", 32'(fault), 32'd1);
    check("both_st_wait", 32'(state_dbg), 32'(WAIT_CLEAR));
    check("both_bar", 32'(barrier_up), 32'd0);
    drive(1'b0, 1'b0);
    cyc(10);
    check("both_st_idle", 32'(state_dbg), 32'(IDLE));
    check("cnt_fault", 32'(cnt_fault), 32'd2);
    check("cnt_out_final", 32'(cnt_out), 32'd2);
    check("pulse_exclusive", 32'(cnt_multi), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
